// File: rtl/div3_seq.sv
// div3_seq: sequential restoring divider, WIDTH shift/subtract iterations behind a start/done handshake.
//
// Ports:
//   clk          clock, all state on posedge
//   reset_n      synchronous active-low reset
//   start        request, sampled only in IDLE
//   dividend     captured on the accepted start edge
//   divisor      captured on the accepted start edge
//   div_signed   two's-complement request (only honoured with SIGNED_DIV_EN)
//   quotient     result register, held until the next done
//   remainder    result register, held until the next done
//   div_by_zero  set with done when the divisor was zero
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse while in DONE
//
// Optional feature macro: SIGNED_DIV_EN (signed division support).
module div3_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dd_mag, ds_mag, fin_quo, fin_rem;
    logic [WIDTH:0]   diff;

`ifdef SIGNED_DIV_EN
    logic dd_neg, ds_neg, qneg_q, qneg_d, rneg_q, rneg_d;
    assign dd_neg = div_signed & dividend[WIDTH-1];
    assign ds_neg = div_signed & divisor[WIDTH-1];
    // The magnitude of MIN is MIN itself read as unsigned, which makes MIN/-1 fall out naturally.
    assign dd_mag = dd_neg ? -dividend : dividend;
    assign ds_mag = ds_neg ? -divisor : divisor;
`else
    logic unused_signed;
    assign unused_signed = div_signed;
    assign dd_mag = dividend;
    assign ds_mag = divisor;
`endif

    // Borrow out of the extended subtraction means rem < dsr.
    assign diff    = {1'b0, rem_q} - {1'b0, dsr_q};
    assign fin_quo = {quo_q[WIDTH-1:1], ~diff[WIDTH]};
    assign fin_rem = diff[WIDTH] ? rem_q : diff[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SIGNED_DIV_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && divisor == '0) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = dividend;
                    dbz_d       = 1'b1;
                end else if (start) begin
                    state_d = SHIFT;
                    rem_d   = '0;
                    quo_d   = dd_mag;
                    dsr_d   = ds_mag;
                    count_d = '0;
`ifdef SIGNED_DIV_EN
                    qneg_d  = dd_neg ^ ds_neg;
                    rneg_d  = dd_neg;
`endif
                end
            end
            SHIFT: begin
                {rem_d, quo_d} = {rem_q, quo_q} << 1;
                state_d        = SUB;
            end
            SUB: begin
                rem_d = fin_rem;
                quo_d = fin_quo;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    dbz_d       = 1'b0;
`ifdef SIGNED_DIV_EN
                    quotient_d  = qneg_q ? -fin_quo : fin_quo;
                    remainder_d = rneg_q ? -fin_rem : fin_rem;
`else
                    quotient_d  = fin_quo;
                    remainder_d = fin_rem;
`endif
                end else begin
                    state_d = SHIFT;
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SIGNED_DIV_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
endmodule

// File: tb/tb_div3_seq.sv
// tb_div3_seq: directed and random checks of div3_seq against an arithmetic reference model.
module tb_div3_seq;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero, busy, done;
    int           total = 0;
    int           bad = 0;

    div3_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dividend(dividend),
        .divisor(divisor), .div_signed(div_signed), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] ds, input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = (ds == '0);
        q = '1;
        r = dd;
        if (z) begin
            q = '1;
            r = dd;
        end
`ifdef SIGNED_DIV_EN
        else if (sg && dd == 32'h8000_0000 && ds == '1) begin
            q = dd;
            r = '0;
        end else if (sg) begin
            q = W'($signed(dd) / $signed(ds));
            r = W'($signed(dd) % $signed(ds));
        end
`endif
        else begin
            q = dd / ds;
            r = dd % ds;
        end
    endfunction

    // Issues one operation, scrambles the inputs after the accept edge and checks result and timing.
    task automatic op(input logic [W-1:0] dd, input logic [W-1:0] ds, input logic sg, input string tag);
        logic [W-1:0] q, r;
        logic         z;
        int           k, bz;
        model(dd, ds, sg, q, r, z);
        @(negedge clk);
        dividend = dd; divisor = ds; div_signed = sg; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; div_signed = 1'($urandom_range(0, 1));
        k = 0; bz = 0;
        while (!done && k < 200) begin
            bz += int'(busy);
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_lat"}, 64'(k), z ? 64'd0 : 64'd64);
            chk({tag, "_busy"}, 64'(bz + int'(busy)), z ? 64'd1 : 64'd65);
            chk({tag, "_q"}, 64'(quotient), 64'(q));
            chk({tag, "_r"}, 64'(remainder), 64'(r));
            chk({tag, "_dbz"}, 64'(div_by_zero), 64'(z));
        end
    endtask

    initial begin
        int pulses, lat;
        repeat (3) @(negedge clk);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;

        op(32'd100, 32'd7, 1'b0, "t1_100_7");
        op(32'hFFFF_FFFF, 32'd1, 1'b0, "t2_max_1");
        op(32'd5, 32'd9, 1'b0, "t2_5_9");
        op(32'd1234, 32'd0, 1'b0, "t3_zero");

        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; div_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; lat = -1;
        for (int k = 0; k < 120; k++) begin
            if (done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 40) begin
                chk("t4_hold_q", 64'(quotient), 64'hFFFF_FFFF);
                chk("t4_hold_dbz", 64'(div_by_zero), 64'd1);
            end
            start = (k == 10 || k == 30);
            if (start) begin
                dividend = $urandom;
                divisor = $urandom | 32'd1;
            end
            @(negedge clk);
        end
        chk("t4_pulses", 64'(pulses), 64'd1);
        chk("t4_lat", 64'(lat), 64'd64);
        chk("t4_q", 64'(quotient), 64'd14);
        chk("t4_r", 64'(remainder), 64'd2);

        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) pulses++;
            if (k == 20) reset_n = 1'b0;
            if (k == 21) begin
                reset_n = 1'b1;
                chk("t5_busy", 64'(busy), 64'd0);
                chk("t5_q", 64'(quotient), 64'd0);
                chk("t5_r", 64'(remainder), 64'd0);
                chk("t5_dbz", 64'(div_by_zero), 64'd0);
            end
            @(negedge clk);
        end
        chk("t5_no_done", 64'(pulses), 64'd0);
        op(32'd100, 32'd7, 1'b0, "t5_again");

        op(32'hFFFF_FFF9, 32'd2, 1'b1, "t6_m7_2");
        op(32'd7, 32'hFFFF_FFFE, 1'b1, "t6_7_m2");
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "t6_min_m1");
        op(32'hFFFF_FFF9, 32'd0, 1'b1, "t6_sgn_zero");

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] dd, ds;
            dd = $urandom;
            ds = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom >> $urandom_range(0, 31);
            op(dd, ds, 1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
